// File: rtl/up_loader_if.sv
// up_loader_if: write port from the serial boot loader into the core's
// 256-byte program memory.
//   mem_addr : byte address of the current write
//   mem_data : byte being written
//   mem_we   : one-cycle write strobe; addr/data hold between strobes
// The loader drives the port through the master modport and the memory
// (or a bench model) observes it through the slave modport.
interface up_loader_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;

    modport master (output mem_addr, output mem_data, output mem_we);
    modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/up_loader.sv
// up_loader: serial boot loader sitting in front of the microprocessor core.
// It receives an 8N1 UART image made of a length byte N (0 meaning 256)
// followed by N data bytes. It writes the data bytes to consecutive memory
// addresses starting at BASE_ADDR, wrapping modulo 256. The core is held in
// reset until the last byte has been written, after which core_nRst and
// done stay high until the next nRst.
//   clk       : single rising-edge clock
//   nRst      : asynchronous active-low reset
//   rx        : UART line, idle high, asynchronous to clk
//   mem       : memory write port (mem_addr, mem_data, mem_we)
//   core_nRst : reset to the core, low while loading
//   done      : sticky, image complete
//   frame_err : sticky, a stop bit was sampled low while loading
module up_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] BASE_ADDR    = 8'h00
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        rx,
    up_loader_if.master mem,
    output logic        core_nRst,
    output logic        done,
    output logic        frame_err
);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} l_state_t;

    // Terminal counts of the bit-period counter: half a bit for the start
    // bit, so that later samples land in the middle of each bit.
    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);

    logic       rx_meta_q, rx_s_q;
    r_state_t   r_state_q, r_state_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       byte_vld, stop_err;

    l_state_t   l_state_q, l_state_d;
    logic [8:0] count_q, count_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       mem_we_q, mem_we_d;
    logic       core_nrst_q, core_nrst_d;
    logic       done_q, done_d;
    logic       frame_err_q, frame_err_d;
    logic       loading;

    // Once the image is complete the receiver output is ignored entirely,
    // so neither writes nor framing errors can happen after done.
    assign loading = (l_state_q != L_DONE);

    // UART receiver: byte_vld and stop_err are single-cycle pulses in the
    // cycle the stop bit is sampled. A start bit that is high again at its
    // midpoint is a glitch and is dropped silently.
    always_comb begin
        r_state_d = r_state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        rx_byte_d = rx_byte_q;
        byte_vld  = 1'b0;
        stop_err  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (!rx_s_q) begin
                    r_state_d = R_START;
                    clk_cnt_d = 8'd0;
                    bit_idx_d = 3'd0;
                end
            end
            R_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = 8'd0;
                    r_state_d = rx_s_q ? R_IDLE : R_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            R_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 8'd0;
                    rx_byte_d = {rx_s_q, rx_byte_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        r_state_d = R_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            R_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 8'd0;
                    r_state_d = R_IDLE;
                    byte_vld  = rx_s_q & loading;
                    stop_err  = ~rx_s_q & loading;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Loader: the first good byte is the length, the rest are written out.
    // A byte lost to a framing error never reaches this logic, so it costs
    // neither count nor address. done/core_nRst are registered off the
    // L_DONE state, which puts their rise one cycle after the last mem_we.
    always_comb begin
        l_state_d   = l_state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = 1'b0;
        frame_err_d = frame_err_q | stop_err;
        core_nrst_d = (l_state_q == L_DONE);
        done_d      = (l_state_q == L_DONE);
        case (l_state_q)
            L_LEN: begin
                if (byte_vld) begin
                    count_d   = (rx_byte_q == 8'd0) ? 9'd256 : {1'b0, rx_byte_q};
                    addr_d    = BASE_ADDR;
                    l_state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (byte_vld) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = rx_byte_q;
                    mem_addr_d = addr_q;
                    addr_d     = addr_q + 8'd1;
                    count_d    = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        l_state_d = L_DONE;
                    end
                end
            end
            L_DONE: l_state_d = L_DONE;
            default: l_state_d = L_LEN;
        endcase
    end

    // All state, including the two-flop rx synchroniser (reset to idle-high).
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            r_state_q   <= R_IDLE;
            clk_cnt_q   <= 8'd0;
            bit_idx_q   <= 3'd0;
            rx_byte_q   <= 8'd0;
            l_state_q   <= L_LEN;
            count_q     <= 9'd0;
            addr_q      <= BASE_ADDR;
            mem_addr_q  <= BASE_ADDR;
            mem_data_q  <= 8'd0;
            mem_we_q    <= 1'b0;
            core_nrst_q <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            r_state_q   <= r_state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            rx_byte_q   <= rx_byte_d;
            l_state_q   <= l_state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
            core_nrst_q <= core_nrst_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_data = mem_data_q;
    assign mem.mem_we   = mem_we_q;
    assign core_nRst    = core_nrst_q;
    assign done         = done_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_up_loader.sv
// tb_up_loader: self-checking bench for up_loader. Two instances share the
// clock and reset: dut0 with BASE_ADDR 8'h00 and dut1 with BASE_ADDR 8'hF0,
// each with its own rx line. Every data byte sent is pushed as an expected
// {addr, data} write into that instance's queue; a monitor pops and compares
// on each mem_we, so any unexpected write shows up as a failure.
module tb_up_loader;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic core_nrst0, done0, ferr0;
    logic core_nrst1, done1, ferr1;

    up_loader_if mif0 ();
    up_loader_if mif1 ();

    up_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .nRst(nRst), .rx(rx0), .mem(mif0),
        .core_nRst(core_nrst0), .done(done0), .frame_err(ferr0)
    );

    up_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'hF0)) dut1 (
        .clk(clk), .nRst(nRst), .rx(rx1), .mem(mif1),
        .core_nRst(core_nrst1), .done(done1), .frame_err(ferr1)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    wr_t exp_q0[$];
    wr_t exp_q1[$];
    int  wr_cnt0 = 0, wr_cnt1 = 0;
    int  last_we0 = 0, last_we1 = 0;
    int  done_rise0 = -100, done_rise1 = -100;
    bit  done_seen0 = 1'b0, done_seen1 = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitors: compare each write against the queue head and
    // record the cycle of the last write and of the rise of done.
    initial forever begin
        @(negedge clk);
        if (mif0.mem_we === 1'b1) begin
            if (exp_q0.size() == 0) begin
                checkOutput("sb0_unexpected_we", 32'(mif0.mem_we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q0.pop_front();
                checkOutput("sb0_addr", 32'(mif0.mem_addr), 32'(e.addr));
                checkOutput("sb0_data", 32'(mif0.mem_data), 32'(e.data));
            end
            wr_cnt0++;
            last_we0 = cyc;
        end
        if (!nRst) done_seen0 = 1'b0;
        else if (done0 === 1'b1 && !done_seen0) begin
            done_seen0 = 1'b1;
            done_rise0 = cyc;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mif1.mem_we === 1'b1) begin
            if (exp_q1.size() == 0) begin
                checkOutput("sb1_unexpected_we", 32'(mif1.mem_we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q1.pop_front();
                checkOutput("sb1_addr", 32'(mif1.mem_addr), 32'(e.addr));
                checkOutput("sb1_data", 32'(mif1.mem_data), 32'(e.data));
            end
            wr_cnt1++;
            last_we1 = cyc;
        end
        if (!nRst) done_seen1 = 1'b0;
        else if (done1 === 1'b1 && !done_seen1) begin
            done_seen1 = 1'b1;
            done_rise1 = cyc;
        end
    end

    task automatic setRx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    // One 8N1 frame with a selectable stop bit, then one idle bit period.
    task automatic applyStimulus(input int which, input logic [7:0] b, input logic stop_bit);
        setRx(which, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            setRx(which, b[i]);
            repeat (CPB) @(negedge clk);
        end
        setRx(which, stop_bit);
        repeat (CPB) @(negedge clk);
        setRx(which, 1'b1);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic sendData(input int which, input logic [7:0] addr, input logic [7:0] b);
        wr_t e;
        e.addr = addr;
        e.data = b;
        if (which == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        applyStimulus(which, b, 1'b1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_addr0"}, 32'(mif0.mem_addr), 32'h00);
        checkOutput({tag, "_addr1"}, 32'(mif1.mem_addr), 32'hF0);
        checkOutput({tag, "_data0"}, 32'(mif0.mem_data), 32'h00);
        checkOutput({tag, "_we0"}, 32'(mif0.mem_we), 32'd0);
        checkOutput({tag, "_we1"}, 32'(mif1.mem_we), 32'd0);
        checkOutput({tag, "_core_nrst0"}, 32'(core_nrst0), 32'd0);
        checkOutput({tag, "_core_nrst1"}, 32'(core_nrst1), 32'd0);
        checkOutput({tag, "_done0"}, 32'(done0), 32'd0);
        checkOutput({tag, "_ferr0"}, 32'(ferr0), 32'd0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        nRst = 1'b0;
        repeat (4) @(negedge clk);
        checkReset("rst_pulse");
        nRst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    int base_cnt;

    initial begin
        // Reset held with rx toggling on both lines.
        nRst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rx0 = 1'($urandom_range(0, 1));
            rx1 = 1'($urandom_range(0, 1));
            if (i % 20 == 19) checkReset("reset_hold");
        end
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (4) @(negedge clk);
        nRst = 1'b1;
        repeat (4) @(negedge clk);
        checkReset("after_reset");

        // Basic load on dut0.
        base_cnt = wr_cnt0;
        applyStimulus(0, 8'h03, 1'b1);
        sendData(0, 8'h00, 8'hA5);
        sendData(0, 8'h01, 8'h3C);
        sendData(0, 8'h02, 8'hFF);
        checkOutput("basic_wr_count", 32'(wr_cnt0 - base_cnt), 32'd3);
        checkOutput("basic_done_latency", 32'(done_rise0 - last_we0), 32'd1);
        checkOutput("basic_core_nrst", 32'(core_nrst0), 32'd1);
        checkOutput("basic_done", 32'(done0), 32'd1);
        applyStimulus(0, 8'h55, 1'b1);
        applyStimulus(0, 8'h66, 1'b0);
        checkOutput("basic_after_done_writes", 32'(wr_cnt0 - base_cnt), 32'd3);
        checkOutput("basic_after_done_ferr", 32'(ferr0), 32'd0);
        checkOutput("basic_still_done", 32'(done0), 32'd1);

        // Glitch then framing error on dut0.
        pulseReset();
        base_cnt = wr_cnt0;
        rx0 = 1'b0;
        repeat (6) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_ferr", 32'(ferr0), 32'd0);
        checkOutput("glitch_done", 32'(done0), 32'd0);
        applyStimulus(0, 8'h02, 1'b1);
        applyStimulus(0, 8'h11, 1'b0);
        checkOutput("ferr_set", 32'(ferr0), 32'd1);
        checkOutput("ferr_no_write", 32'(wr_cnt0 - base_cnt), 32'd0);
        sendData(0, 8'h00, 8'h22);
        checkOutput("ferr_not_done_early", 32'(done0), 32'd0);
        sendData(0, 8'h01, 8'h33);
        checkOutput("ferr_wr_count", 32'(wr_cnt0 - base_cnt), 32'd2);
        checkOutput("ferr_done_latency", 32'(done_rise0 - last_we0), 32'd1);
        checkOutput("ferr_sticky", 32'(ferr0), 32'd1);

        // Full 256-byte image on dut1, wrapping from FF to 00.
        base_cnt = wr_cnt1;
        applyStimulus(1, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'hF0 + 8'(i);
            sendData(1, a, 8'(i));
            if (i == 254) checkOutput("wrap_not_done_255", 32'(done1), 32'd0);
        end
        checkOutput("wrap_wr_count", 32'(wr_cnt1 - base_cnt), 32'd256);
        checkOutput("wrap_done_latency", 32'(done_rise1 - last_we1), 32'd1);
        checkOutput("wrap_core_nrst", 32'(core_nrst1), 32'd1);

        // Reset in the middle of a load on dut0.
        pulseReset();
        base_cnt = wr_cnt0;
        applyStimulus(0, 8'h05, 1'b1);
        sendData(0, 8'h00, 8'h81);
        sendData(0, 8'h01, 8'h82);
        checkOutput("midload_core_nrst_before", 32'(core_nrst0), 32'd0);
        pulseReset();
        checkOutput("midload_core_nrst_after", 32'(core_nrst0), 32'd0);
        applyStimulus(0, 8'h01, 1'b1);
        sendData(0, 8'h00, 8'h77);
        checkOutput("midload_wr_count", 32'(wr_cnt0 - base_cnt), 32'd3);
        checkOutput("midload_done_latency", 32'(done_rise0 - last_we0), 32'd1);
        checkOutput("midload_done", 32'(done0), 32'd1);

        repeat (10) @(negedge clk);
        checkOutput("sb0_empty", 32'(exp_q0.size()), 32'd0);
        checkOutput("sb1_empty", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_loader.md
# up_loader

Serial boot loader upstream of the microprocessor core. Receives a program image over an 8N1 UART line and writes it byte-by-byte into the core's 256-byte memory through a write port. It holds the core in reset (`core_nRst` low) until the image is fully written, then releases it permanently until the next `nRst`.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per UART bit. Legal range is 4..255.
- `BASE_ADDR`, 8'h00: memory address of the first image byte.
- `clk`  in  1: single clock. All state is clocked on the rising edge.
- `nRst`  in  1: reset, asynchronous and active-low.
- `rx`  in  1: UART receive line. Idle high. Asynchronous to `clk`.
- `mem_addr`  out  8: write address into core memory.
- `mem_data`  out  8: write data.
- `mem_we`  out  1: one-cycle write strobe.
- `core_nRst`  out  1: reset to the core. Low while loading.
- `done`  out  1: high once the image is complete. Sticky.
- `frame_err`  out  1: sticky flag, set by any stop-bit error.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchroniser, reset value 1. All decisions use the synchronised value `rx_s`.
- **Receiver FSM**
  - `R_IDLE`: on `rx_s`=0, go to `R_START` and clear the bit counter.
  - `R_START`: wait `CLKS_PER_BIT/2` cycles (integer division), then sample.
    - Sample is 0: go to `R_DATA`.
    - Sample is 1: treat as a glitch and return to `R_IDLE`. No error is flagged.
  - `R_DATA`: sample every `CLKS_PER_BIT` cycles, 8 samples, LSB first, shifted into `rx_byte`. Then go to `R_STOP`.
  - `R_STOP`: sample after `CLKS_PER_BIT` cycles.
    - Sample is 1: pulse `byte_vld` for 1 cycle.
    - Sample is 0: set `frame_err` and drop the byte.
    - In both cases, return to `R_IDLE`.
- **Loader FSM**
  - `L_LEN`: the first valid byte is the length N. A value of 0 means 256. Store it in a 9-bit count, set `addr` to `BASE_ADDR`, go to `L_DATA`.
  - `L_DATA`: on each `byte_vld`:
    - Drive `mem_data`=byte and `mem_addr`=`addr`, assert `mem_we` for 1 cycle.
    - Increment `addr` modulo 256; it wraps from 8'hFF to 8'h00.
    - Decrement the count.
    - When the count reaches 0 after a write, go to `L_DONE`.
  - `L_DONE`: `done`=1, `core_nRst`=1. All further `rx` activity is ignored. No writes occur and `frame_err` is not updated. Only `nRst` exits this state.
- **Dropped bytes:** a byte dropped for a framing error does not consume count or address. The next good byte goes to the same address.
- **Length byte errors:** a framing error on the length byte leaves the FSM in `L_LEN`.

## Timing
- **Reset values:**
  - `mem_addr`=`BASE_ADDR`, `mem_data`=0, `mem_we`=0.
  - `core_nRst`=0, `done`=0, `frame_err`=0.
  - Both FSMs in their first state (`R_IDLE`, `L_LEN`).
- **Latency:**
  - The `rx` falling edge reaches `rx_s` after 2 cycles.
  - `byte_vld` fires in the cycle the stop bit is sampled.
  - `mem_we` is registered and asserts the cycle after `byte_vld`.
  - `mem_addr`/`mem_data` are valid in the same cycle as `mem_we` and hold until the next write.
- **Release:** `core_nRst` and `done` rise together, 1 cycle after the final `mem_we`. Both are registered and glitch-free.
- **Back-to-back bytes:** a start bit may immediately follow a stop-bit sample. `R_IDLE` detects it on the next cycle. The minimum spacing between writes is 10×`CLKS_PER_BIT` cycles.
- **Reset mid-load:** `nRst` low at any point aborts the load and returns all outputs to reset values, including `core_nRst` going low. Memory already written is not touched. The next image starts again from a length byte.
- **Counters:** the bit-period counter is 8 bits and the bit index is 3 bits. Neither overflows within the legal parameter range.

## Test plan
- **Reset:** hold `nRst` low with `rx` toggling.
  - Required: all outputs at reset values; no `mem_we`.
- **Basic load:** `CLKS_PER_BIT`=16, send 0x03, 0xA5, 0x3C, 0xFF.
  - Required: `mem_we` at addr 0/1/2 with data A5/3C/FF.
  - Required: `core_nRst`=`done`=1 exactly 1 cycle after the third `mem_we`.
  - Required: bytes sent afterwards produce no writes.
- **Glitch and framing error:**
  - Send a 6-cycle low pulse on `rx`. Required: ignored, with no error.
  - Then send length 0x02, then 0x11 with stop bit 0, then 0x22, 0x33. Required: `frame_err`=1; writes 22@00 and 33@01; `done` rises after 33.
- **Full-size wrap:** `BASE_ADDR`=8'hF0, length 0x00, then 256 bytes with data=index.
  - Required: 256 writes.
  - Required: addr F0..FF then 00..EF, with data matching index.
  - Required: `done` after the 256th write only.
- **Reset mid-load:** send length 5 and 2 data bytes, then pulse `nRst`. Then send length 1 and 0x77.
  - Required: `core_nRst` low during and after the pulse.
  - Required: single write 77@`BASE_ADDR`, then `done`.
